// File: rtl/pc_unit.sv
// pc_unit: program counter with branch/jump/register redirects, stall hold and captured-redirect replay.
module pc_unit #(
  parameter int WIDTH = 32,
  parameter int STEP = 4,
  parameter int ALIGN_BITS = 2,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          redirect_valid,
  input  logic [1:0]                    redirect_mode,
  input  logic [WIDTH-1:0]              branch_offset,
  input  logic [WIDTH-4-ALIGN_BITS-1:0] jump_index,
  input  logic [WIDTH-1:0]              reg_target,
  output logic [WIDTH-1:0]              pc,
  output logic [WIDTH-1:0]              pc_plus,
  output logic                          pending,
  output logic                          misalign_err
);
  localparam logic [WIDTH-1:0] AMASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
  typedef enum logic {RUN, HOLD} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] cap, cap_nx, pc_nx, target;
  logic [WIDTH-5:0] jump_low;
  logic misaligned, req;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      pc <= RESET_VECTOR;
      cap <= '0;
      misalign_err <= 1'b0;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      cap <= cap_nx;
      misalign_err <= misalign_err | misaligned;
    end
  end
  // a misaligned register jump is dropped entirely, so it never disturbs a captured target
  always_comb begin
    jump_low = (WIDTH-4)'(jump_index) << ALIGN_BITS;
    target = redirect_mode == 2'b00 ? pc_plus + (branch_offset << ALIGN_BITS)
           : redirect_mode == 2'b01 ? {pc_plus[WIDTH-1:WIDTH-4], jump_low}
           : reg_target;
    misaligned = redirect_valid && redirect_mode == 2'b10 && |(reg_target & AMASK);
    req = redirect_valid && redirect_mode != 2'b11 && !misaligned;
    state_nx = stall && (req || state == HOLD) ? HOLD : RUN;
    cap_nx = stall && req ? target : cap;
    pc_nx = stall ? pc : req ? target : state == HOLD ? cap : pc_plus;
  end
  always_comb begin
    pending = state == HOLD;
    pc_plus = pc + WIDTH'(STEP);
  end
endmodule
